// File: rtl/disp_pkg.sv
// Shared display types: character codes, segment constants, decoder.
// Used by display_manager and seg_scan_driver.
package disp_pkg;

  typedef logic [5:0] char_code_t;
  typedef logic [6:0] seg_t;

  localparam char_code_t CH_0     = 6'd0;
  localparam char_code_t CH_1     = 6'd1;
  localparam char_code_t CH_2     = 6'd2;
  localparam char_code_t CH_3     = 6'd3;
  localparam char_code_t CH_4     = 6'd4;
  localparam char_code_t CH_5     = 6'd5;
  localparam char_code_t CH_6     = 6'd6;
  localparam char_code_t CH_7     = 6'd7;
  localparam char_code_t CH_8     = 6'd8;
  localparam char_code_t CH_9     = 6'd9;
  localparam char_code_t CH_A     = 6'd10;
  localparam char_code_t CH_J     = 6'd11;
  localparam char_code_t CH_U     = 6'd12;
  localparam char_code_t CH_P     = 6'd13;
  localparam char_code_t CH_E     = 6'd14;
  localparam char_code_t CH_L     = 6'd15;
  localparam char_code_t CH_T     = 6'd16;
  localparam char_code_t CH_Y     = 6'd17;
  localparam char_code_t CH_B     = 6'd18;
  localparam char_code_t CH_G     = 6'd19;
  localparam char_code_t CH_S     = 6'd20;
  localparam char_code_t CH_R     = 6'd21;
  localparam char_code_t CH_N     = 6'd22;
  localparam char_code_t CH_DASH  = 6'd23;
  localparam char_code_t CH_BLANK = 6'b100000;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic seg_t char_to_seg(
    input char_code_t c
  );
    seg_t s;
    if (c[5]) begin
      s = SEG_OFF;
    end else begin
      case (c[4:0])
        5'd0:    s = 7'h40;
        5'd1:    s = 7'h79;
        5'd2:    s = 7'h24;
        5'd3:    s = 7'h30;
        5'd4:    s = 7'h19;
        5'd5:    s = 7'h12;
        5'd6:    s = 7'h02;
        5'd7:    s = 7'h78;
        5'd8:    s = 7'h00;
        5'd9:    s = 7'h10;
        5'd10:   s = 7'h08;
        5'd11:   s = 7'h61;
        5'd12:   s = 7'h41;
        5'd13:   s = 7'h0C;
        5'd14:   s = 7'h06;
        5'd15:   s = 7'h47;
        5'd16:   s = 7'h07;
        5'd17:   s = 7'h11;
        5'd18:   s = 7'h03;
        5'd19:   s = 7'h42;
        5'd20:   s = 7'h12;
        5'd21:   s = 7'h2F;
        5'd22:   s = 7'h2B;
        5'd23:   s = 7'h3F;
        default: s = SEG_OFF;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational character-code to 7-segment decoder.
// Ports: code (6b char code) -> seg (7b active-low {g..a}).
module seg_decoder
  import disp_pkg::*;
(
  input  logic [5:0] code,
  output logic [6:0] seg
);

  assign seg = char_to_seg(code);

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit common-anode scan driver with per-frame snapshot and blanking.
// Ports: clock, reset(n), d1..d8, blink -> an, seg, frame_start. Opt: SCAN_BLINK_EN.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic       blink,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [5:0]    frame_buf [8];
  logic [5:0]    d_in [8];
  logic [6:0]    cur_seg;
  logic          snap;
  logic          in_blank;
  logic          blink_off;

  assign d_in[0] = d1;
  assign d_in[1] = d2;
  assign d_in[2] = d3;
  assign d_in[3] = d4;
  assign d_in[4] = d5;
  assign d_in[5] = d6;
  assign d_in[6] = d7;
  assign d_in[7] = d8;

  assign snap     = (cnt == '0) && (idx == 3'd0);
  assign in_blank = cnt < CW'(BLANK_CYCLES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        frame_buf[k] <= CH_BLANK;
      end
    end else if (snap) begin
      for (int k = 0; k < 8; k++) begin
        frame_buf[k] <= d_in[k];
      end
    end
  end

  seg_decoder u_dec (
    .code (frame_buf[idx]),
    .seg  (cur_seg)
  );

`ifdef SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] fcnt;
  logic          blink_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (!blink) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign blink_off = blink & blink_phase;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blink_off    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an          <= 8'hFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (in_blank) begin
        an  <= 8'hFF;
        seg <= SEG_OFF;
      end else begin
        an  <= blink_off ? 8'hFF : ~(8'h80 >> idx);
        seg <= cur_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver.
// Two instances: BLANK_CYCLES=1 (u0) and BLANK_CYCLES=2 (u1).
module tb_seg_scan_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       blink = 1'b0;
  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       fs0, fs1;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  logic [6:0] exp_tab [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h61,
    7'h41, 7'h0C, 7'h06, 7'h47,
    7'h07, 7'h11, 7'h03, 7'h42,
    7'h12, 7'h2F, 7'h2B, 7'h3F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  always #5 clock = ~clock;

  seg_scan_driver #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1),
    .BLINK_FRAMES(50)
  ) u0 (
    .clock      (clock),
    .reset      (reset),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .d6         (d6),
    .d7         (d7),
    .d8         (d8),
    .blink      (blink),
    .an         (an0),
    .seg        (seg0),
    .frame_start(fs0)
  );

  seg_scan_driver #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2),
    .BLINK_FRAMES(2)
  ) u1 (
    .clock      (clock),
    .reset      (reset),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .d6         (d6),
    .d7         (d7),
    .d8         (d8),
    .blink      (blink),
    .an         (an1),
    .seg        (seg1),
    .frame_start(fs1)
  );

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    k++;
  endtask

  // Expected anode after edge kk (edge 1 = first after reset release)
  function automatic logic [7:0] exp_an(int kk, int bl);
    int c, i;
    c = (kk - 1) % 4;
    i = ((kk - 1) / 4) % 8;
    return (c < bl) ? 8'hFF : ~(8'h80 >> i);
  endfunction

  function automatic logic [6:0] exp_sg(
    int kk, int bl, logic [6:0] s0, logic [6:0] s1
  );
    int c, i;
    c = (kk - 1) % 4;
    i = ((kk - 1) / 4) % 8;
    if (c < bl) return 7'h7F;
    if (i == 0) return s0;
    if (i == 1) return s1;
    return 7'h7F;
  endfunction

  task automatic test_reset();
    logic fs_e;
    reset = 1'b0;
    d1 = 6'd11; d2 = 6'd1;
    d3 = 6'h20; d4 = 6'h20; d5 = 6'h20;
    d6 = 6'h20; d7 = 6'h20; d8 = 6'h20;
    repeat (3) @(negedge clock);
    total++;
    if (an0 !== 8'hFF) begin
      bad++;
      $display("FAIL rst_an got=%h want=ff", an0);
    end
    total++;
    if (seg0 !== 7'h7F) begin
      bad++;
      $display("FAIL rst_seg got=%h want=7f", seg0);
    end
    total++;
    if (fs0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_fs got=%b want=0", fs0);
    end
    reset = 1'b1;
    k = 0;
    for (int n = 0; n < 32; n++) begin
      step();
      fs_e = ((k - 1) % 32) == 0;
      total++;
      if (an0 !== exp_an(k, 1)) begin
        bad++;
        $display("FAIL scan_an k=%0d got=%h want=%h",
                 k, an0, exp_an(k, 1));
      end
      total++;
      if (seg0 !== exp_sg(k, 1, 7'h61, 7'h79)) begin
        bad++;
        $display("FAIL scan_seg k=%0d got=%h want=%h",
                 k, seg0, exp_sg(k, 1, 7'h61, 7'h79));
      end
      total++;
      if (fs0 !== fs_e) begin
        bad++;
        $display("FAIL scan_fs k=%0d got=%b want=%b",
                 k, fs0, fs_e);
      end
    end
  endtask

  task automatic test_snapshot();
    step();
    d1 = 6'd2;
    for (int n = 0; n < 31; n++) begin
      step();
      total++;
      if (seg0 !== exp_sg(k, 1, 7'h61, 7'h79)) begin
        bad++;
        $display("FAIL snap_old k=%0d got=%h want=%h",
                 k, seg0, exp_sg(k, 1, 7'h61, 7'h79));
      end
    end
    for (int n = 0; n < 32; n++) begin
      step();
      total++;
      if (seg0 !== exp_sg(k, 1, 7'h24, 7'h79)) begin
        bad++;
        $display("FAIL snap_new k=%0d got=%h want=%h",
                 k, seg0, exp_sg(k, 1, 7'h24, 7'h79));
      end
      if (k == 65) begin
        total++;
        if (fs0 !== 1'b1) begin
          bad++;
          $display("FAIL snap_fs got=%b want=1", fs0);
        end
      end
    end
  endtask

  task automatic test_blanking();
    for (int n = 0; n < 32; n++) begin
      step();
      total++;
      if (an1 !== exp_an(k, 2)) begin
        bad++;
        $display("FAIL blank_an k=%0d got=%h want=%h",
                 k, an1, exp_an(k, 2));
      end
      total++;
      if (seg1 !== exp_sg(k, 2, 7'h24, 7'h79)) begin
        bad++;
        $display("FAIL blank_seg k=%0d got=%h want=%h",
                 k, seg1, exp_sg(k, 2, 7'h24, 7'h79));
      end
      total++;
      if ($countones(~an1) > 1) begin
        bad++;
        $display("FAIL onehot k=%0d got=%h want<=1 low",
                 k, an1);
      end
    end
  endtask

  task automatic test_decode();
    logic [6:0] e;
    for (int code = 0; code < 64; code++) begin
      d8 = 6'(code);
      repeat (31) step();
      e = (code < 32) ? exp_tab[code] : 7'h7F;
      total++;
      if (seg0 !== e) begin
        bad++;
        $display("FAIL decode code=%0d got=%h want=%h",
                 code, seg0, e);
      end
      step();
    end
    d8 = 6'h20;
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 32; n++) begin
      if ((k % 32) != 23) step();
    end
    total++;
    if (an0 !== 8'hFB) begin
      bad++;
      $display("FAIL pre_rst_an got=%h want=fb", an0);
    end
    reset = 1'b0;
    #1;
    total++;
    if (an0 !== 8'hFF || an1 !== 8'hFF) begin
      bad++;
      $display("FAIL async_an got=%h/%h want=ff",
               an0, an1);
    end
    total++;
    if (seg0 !== 7'h7F) begin
      bad++;
      $display("FAIL async_seg got=%h want=7f", seg0);
    end
    d1 = 6'd10;
    @(negedge clock);
    reset = 1'b1;
    k = 0;
    step();
    total++;
    if (an0 !== 8'hFF || fs0 !== 1'b1) begin
      bad++;
      $display("FAIL rescan1 an=%h fs=%b want=ff/1",
               an0, fs0);
    end
    step();
    total++;
    if (an0 !== 8'h7F || seg0 !== 7'h08) begin
      bad++;
      $display("FAIL rescan2 an=%h seg=%h want=7f/08",
               an0, seg0);
    end
  endtask

`ifdef SCAN_BLINK_EN
  task automatic test_blink();
    logic [7:0] e;
    reset = 1'b0;
    @(negedge clock);
    blink = 1'b1;
    reset = 1'b1;
    k = 0;
    for (int f = 0; f < 6; f++) begin
      while (k < 32 * f + 3) step();
      e = ((((f + 1) / 2) % 2) == 1) ? 8'hFF : 8'h7F;
      total++;
      if (an1 !== e) begin
        bad++;
        $display("FAIL blink f=%0d got=%h want=%h",
                 f, an1, e);
      end
    end
    blink = 1'b0;
    for (int n = 0; n < 32; n++) begin
      step();
      total++;
      if (an1 !== exp_an(k, 2)) begin
        bad++;
        $display("FAIL noblink k=%0d got=%h want=%h",
                 k, an1, exp_an(k, 2));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_snapshot();
    test_blanking();
    test_decode();
    test_async_reset();
`ifdef SCAN_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
